// File: rtl/lsu_arb_pkg.sv
// -----------------------------------------------------------------------------
// lsu_arb_pkg
// Shared types and width constants for the two-port LSU arbiter.
//   arb_state_e : arbiter FSM state (normal priority / port-1 burst lock)
//   port_id_t   : requester index (0 = CPU MEM stage, 1 = loader/DMA master)
//   rsp_tag_t   : per-request response tag carried down the read-latency pipe
// -----------------------------------------------------------------------------
package lsu_arb_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BMASK_W = 4;

    typedef enum logic [0:0] {
        ST_NORM = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    typedef logic [0:0] port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_AUX = 1'b1;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rsp_tag_t;

endpackage

// File: rtl/lsu_arb_rsp_pipe.sv
// -----------------------------------------------------------------------------
// lsu_arb_rsp_pipe
// Tracks which requester owns each read in flight to the LSU and steers the
// returning data to that requester exactly RD_LAT cycles after the grant.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_push_valid          a read was granted this cycle (writes push 0)
//   i_push_port           which requester owns the granted read
//   i_lsu_rdata           read data from the LSU, valid at the pipe tail
//   o_p0_rvalid/o_p0_rdata  CPU response (rdata holds between responses)
//   o_p1_rvalid/o_p1_rdata  secondary-master response
// -----------------------------------------------------------------------------
module lsu_arb_rsp_pipe
    import lsu_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push_valid,
    input  port_id_t          i_push_port,
    input  logic [DATA_W-1:0] i_lsu_rdata,
    output logic              o_p0_rvalid,
    output logic [DATA_W-1:0] o_p0_rdata,
    output logic              o_p1_rvalid,
    output logic [DATA_W-1:0] o_p1_rdata
);

    rsp_tag_t          tags [RD_LAT];
    rsp_tag_t          tail;
    logic [DATA_W-1:0] p0_hold;
    logic [DATA_W-1:0] p1_hold;

    // Stage 0 captures the grant; each further stage adds one cycle of latency.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= '{valid: i_push_valid, port: i_push_port};
            for (int i = 1; i < RD_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    assign tail        = tags[RD_LAT-1];
    assign o_p0_rvalid = tail.valid && (tail.port == PORT_CPU);
    assign o_p1_rvalid = tail.valid && (tail.port == PORT_AUX);

    // The LSU data is only valid in the tail cycle, so the owning port sees
    // it directly and a copy is kept so the port output holds afterwards.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            p0_hold <= '0;
            p1_hold <= '0;
        end else begin
            if (o_p0_rvalid) begin
                p0_hold <= i_lsu_rdata;
            end
            if (o_p1_rvalid) begin
                p1_hold <= i_lsu_rdata;
            end
        end
    end

    assign o_p0_rdata = o_p0_rvalid ? i_lsu_rdata : p0_hold;
    assign o_p1_rdata = o_p1_rvalid ? i_lsu_rdata : p1_hold;

endmodule

// File: rtl/lsu_arb.sv
// -----------------------------------------------------------------------------
// lsu_arb
// Two-requester arbiter in front of the single MEM-stage LSU.
//   Port 0: pipeline MEM stage (CPU loads/stores), normally highest priority.
//   Port 1: secondary master (program loader / DMA), bounded starvation via a
//           wait counter, optional burst lock (i_p1_lock).
// One access is granted per cycle (combinationally); the granted port drives
// the LSU bus and returning read data is routed back by the response pipe.
//
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_pN_req/wren/addr/wdata/bmask requester N access (held until granted)
//   i_p1_lock                      port-1 burst lock request
//   o_pN_gnt                       requester N accepted this cycle
//   o_pN_rvalid/o_pN_rdata         requester N read response
//   o_lsu_addr/wdata/bmask/wren    LSU request bus (all zero when idle)
//   i_lsu_rdata                    LSU read data, RD_LAT cycles after grant
//   o_stall_mem                    CPU request pending but not granted
//
// Optional build macro LSU_ARB_PERF_EN adds:
//   o_perf_conflict (32b)  cycles with both requests high, saturating
//   o_perf_forced   (16b)  forced starvation grants to port 1, saturating
// -----------------------------------------------------------------------------
module lsu_arb
    import lsu_arb_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8,
    parameter int LOCK_MAX   = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,

    input  logic               i_p0_req,
    input  logic               i_p0_wren,
    input  logic [ADDR_W-1:0]  i_p0_addr,
    input  logic [DATA_W-1:0]  i_p0_wdata,
    input  logic [BMASK_W-1:0] i_p0_bmask,
    output logic               o_p0_gnt,
    output logic               o_p0_rvalid,
    output logic [DATA_W-1:0]  o_p0_rdata,

    input  logic               i_p1_req,
    input  logic               i_p1_wren,
    input  logic [ADDR_W-1:0]  i_p1_addr,
    input  logic [DATA_W-1:0]  i_p1_wdata,
    input  logic [BMASK_W-1:0] i_p1_bmask,
    input  logic               i_p1_lock,
    output logic               o_p1_gnt,
    output logic               o_p1_rvalid,
    output logic [DATA_W-1:0]  o_p1_rdata,

    output logic [ADDR_W-1:0]  o_lsu_addr,
    output logic [DATA_W-1:0]  o_lsu_wdata,
    output logic [BMASK_W-1:0] o_lsu_bmask,
    output logic               o_lsu_wren,
    input  logic [DATA_W-1:0]  i_lsu_rdata,

    output logic               o_stall_mem
`ifdef LSU_ARB_PERF_EN
    ,
    output logic [31:0]        o_perf_conflict,
    output logic [15:0]        o_perf_forced
`endif
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [7:0] LOCK_LIM   = 8'(LOCK_MAX);

    arb_state_e state;
    arb_state_e state_nxt;
    logic [7:0] starve_cnt;
    logic [7:0] starve_nxt;
    logic [7:0] lock_cnt;
    logic [7:0] lock_nxt;

    logic       in_lock;
    logic       lock_hold;
    logic       lock_break;
    logic       starved;
    logic       gnt0;
    logic       gnt1;
    logic       push_valid;
    port_id_t   push_port;

    // Grant decision. lock_cnt already counts the grant that entered the
    // lock, so a burst never exceeds LOCK_MAX consecutive port-1 grants; the
    // cycle that finds the limit reached arbitrates with normal priority.
    always_comb begin
        in_lock    = (state == ST_LOCK);
        lock_hold  = in_lock && i_p1_req && i_p1_lock && (lock_cnt != LOCK_LIM);
        lock_break = in_lock && (lock_cnt == LOCK_LIM);
        starved    = (starve_cnt == STARVE_LIM);
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (!i_reset) begin
            if (lock_hold) begin
                gnt1 = 1'b1;
            end else if (i_p1_req && (!i_p0_req || starved)) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = i_p0_req;
            end
        end
    end

    assign o_p0_gnt    = gnt0;
    assign o_p1_gnt    = gnt1;
    assign o_stall_mem = i_p0_req & ~gnt0;

    // LSU request bus: granted port's fields, all zero when nobody is granted.
    always_comb begin
        o_lsu_addr  = '0;
        o_lsu_wdata = '0;
        o_lsu_bmask = '0;
        o_lsu_wren  = 1'b0;
        if (gnt0) begin
            o_lsu_addr  = i_p0_addr;
            o_lsu_wdata = i_p0_wdata;
            o_lsu_bmask = i_p0_bmask;
            o_lsu_wren  = i_p0_wren;
        end else if (gnt1) begin
            o_lsu_addr  = i_p1_addr;
            o_lsu_wdata = i_p1_wdata;
            o_lsu_bmask = i_p1_bmask;
            o_lsu_wren  = i_p1_wren;
        end
    end

    // Next-state and counter update. Breaking a lock on LOCK_MAX clears the
    // wait counter so port 0 is guaranteed the following contested cycles.
    always_comb begin
        state_nxt  = ST_NORM;
        lock_nxt   = '0;
        starve_nxt = starve_cnt;

        if (gnt1 || !i_p1_req || lock_break) begin
            starve_nxt = '0;
        end else if (!starved) begin
            starve_nxt = starve_cnt + 8'd1;
        end

        if (lock_hold) begin
            state_nxt = ST_LOCK;
            lock_nxt  = lock_cnt + 8'd1;
        end else if (gnt1 && i_p1_lock) begin
            state_nxt = ST_LOCK;
            lock_nxt  = 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_NORM;
            starve_cnt <= '0;
            lock_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            lock_cnt   <= lock_nxt;
        end
    end

    // Only granted reads produce a response; writes push an empty tag.
    assign push_valid = (gnt0 | gnt1) & ~o_lsu_wren;
    assign push_port  = gnt1 ? PORT_AUX : PORT_CPU;

    lsu_arb_rsp_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rsp_pipe (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_push_valid (push_valid),
        .i_push_port  (push_port),
        .i_lsu_rdata  (i_lsu_rdata),
        .o_p0_rvalid  (o_p0_rvalid),
        .o_p0_rdata   (o_p0_rdata),
        .o_p1_rvalid  (o_p1_rvalid),
        .o_p1_rdata   (o_p1_rdata)
    );

`ifdef LSU_ARB_PERF_EN
    logic        forced;
    logic [31:0] perf_conflict;
    logic [15:0] perf_forced;

    // A forced grant is a port-1 grant won against a pending CPU request
    // outside of a held lock.
    assign forced = gnt1 && i_p0_req && !lock_hold;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            perf_conflict <= '0;
            perf_forced   <= '0;
        end else begin
            if (i_p0_req && i_p1_req && (perf_conflict != '1)) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
            if (forced && (perf_forced != '1)) begin
                perf_forced <= perf_forced + 16'd1;
            end
        end
    end

    assign o_perf_conflict = perf_conflict;
    assign o_perf_forced   = perf_forced;
`endif

endmodule

// File: tb/tb_lsu_arb.sv
// -----------------------------------------------------------------------------
// tb_lsu_arb
// Drives two arbiter instances (read latency 3 and 1) with the same requests
// and compares every cycle against a behavioural model of the arbitration
// rules, an LSU memory model and a grant-history scoreboard for responses.
// -----------------------------------------------------------------------------
module tb_lsu_arb;
    import lsu_arb_pkg::*;

    localparam int LAT_A = 3;
    localparam int LAT_B = 1;
    localparam int SMAX  = 8;
    localparam int LMAX  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        p0_req = 0, p0_wren = 0, p1_req = 0, p1_wren = 0, p1_lock = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic [3:0]  p0_bmask = 0, p1_bmask = 0;
    logic [31:0] lsu_rdata_a = 0, lsu_rdata_b = 0;

    logic        gnt0_a, gnt1_a, rv0_a, rv1_a, wren_a, stall_a;
    logic [31:0] rd0_a, rd1_a, addr_a, wdata_a;
    logic [3:0]  bmask_a;
    logic        gnt0_b, gnt1_b, rv0_b, rv1_b, wren_b, stall_b;
    logic [31:0] rd0_b, rd1_b, addr_b, wdata_b;
    logic [3:0]  bmask_b;
`ifdef LSU_ARB_PERF_EN
    logic [31:0] conf_a, conf_b;
    logic [15:0] forc_a, forc_b;
`endif

    lsu_arb #(.RD_LAT(LAT_A), .STARVE_MAX(SMAX), .LOCK_MAX(LMAX)) u_dut_a (
        .i_clk(clk), .i_reset(rst),
        .i_p0_req(p0_req), .i_p0_wren(p0_wren), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_bmask(p0_bmask),
        .o_p0_gnt(gnt0_a), .o_p0_rvalid(rv0_a), .o_p0_rdata(rd0_a),
        .i_p1_req(p1_req), .i_p1_wren(p1_wren), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_bmask(p1_bmask),
        .i_p1_lock(p1_lock), .o_p1_gnt(gnt1_a), .o_p1_rvalid(rv1_a), .o_p1_rdata(rd1_a),
        .o_lsu_addr(addr_a), .o_lsu_wdata(wdata_a), .o_lsu_bmask(bmask_a), .o_lsu_wren(wren_a),
        .i_lsu_rdata(lsu_rdata_a), .o_stall_mem(stall_a)
`ifdef LSU_ARB_PERF_EN
        , .o_perf_conflict(conf_a), .o_perf_forced(forc_a)
`endif
    );

    lsu_arb #(.RD_LAT(LAT_B), .STARVE_MAX(SMAX), .LOCK_MAX(LMAX)) u_dut_b (
        .i_clk(clk), .i_reset(rst),
        .i_p0_req(p0_req), .i_p0_wren(p0_wren), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_bmask(p0_bmask),
        .o_p0_gnt(gnt0_b), .o_p0_rvalid(rv0_b), .o_p0_rdata(rd0_b),
        .i_p1_req(p1_req), .i_p1_wren(p1_wren), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_bmask(p1_bmask),
        .i_p1_lock(p1_lock), .o_p1_gnt(gnt1_b), .o_p1_rvalid(rv1_b), .o_p1_rdata(rd1_b),
        .o_lsu_addr(addr_b), .o_lsu_wdata(wdata_b), .o_lsu_bmask(bmask_b), .o_lsu_wren(wren_b),
        .i_lsu_rdata(lsu_rdata_b), .o_stall_mem(stall_b)
`ifdef LSU_ARB_PERF_EN
        , .o_perf_conflict(conf_b), .o_perf_forced(forc_b)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model state
    bit          m_lock;
    int          m_run;
    int          m_wait;
    bit          hv [8];
    bit          hp [8];
    logic [31:0] hd [8];
    logic [31:0] ha_a [8];
    logic [31:0] ha_b [8];
    logic [31:0] erd0_a, erd1_a, erd0_b, erd1_b;
`ifdef LSU_ARB_PERF_EN
    int          m_conf;
    int          m_forc;
`endif

    // LSU memory contents as a pure function of the address
    function automatic logic [31:0] rmem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_lock = 0;
        m_run  = 0;
        m_wait = 0;
        for (int i = 0; i < 8; i++) hv[i] = 0;
        erd0_a = 0; erd1_a = 0; erd0_b = 0; erd1_b = 0;
`ifdef LSU_ARB_PERF_EN
        m_conf = 0;
        m_forc = 0;
`endif
    endtask

    // One clock cycle: drive inputs, check all outputs against the model,
    // then advance the model past the coming rising edge.
    task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic [3:0] m0, input logic r1, input logic w1, input logic [31:0] a1,
                        input logic [31:0] d1, input logic [3:0] m1, input logic l1);
        bit          hold, brk, g0, g1;
        logic [31:0] ea, ed;
        logic [3:0]  em;
        logic        ew;
        bit          ev0a, ev1a, ev0b, ev1b;
        int          ia, ib, ic;
        @(negedge clk);
        p0_req = r0; p0_wren = w0; p0_addr = a0; p0_wdata = d0; p0_bmask = m0;
        p1_req = r1; p1_wren = w1; p1_addr = a1; p1_wdata = d1; p1_bmask = m1; p1_lock = l1;
        ia = (cyc + 8 - LAT_A) % 8;
        ib = (cyc + 8 - LAT_B) % 8;
        ic = cyc % 8;
        lsu_rdata_a = rmem(ha_a[ia]);
        lsu_rdata_b = rmem(ha_b[ib]);
        #1;
        // Arbitration rules
        hold = m_lock && r1 && l1 && (m_run < LMAX);
        brk  = m_lock && (m_run == LMAX);
        g1   = hold || (r1 && (!r0 || (m_wait == SMAX)));
        g0   = !g1 && r0;
        ea = g0 ? a0 : (g1 ? a1 : 32'h0);
        ed = g0 ? d0 : (g1 ? d1 : 32'h0);
        em = g0 ? m0 : (g1 ? m1 : 4'h0);
        ew = g0 ? w0 : (g1 ? w1 : 1'b0);
        // Responses due now, by grant history
        ev0a = hv[ia] && !hp[ia];
        ev1a = hv[ia] && hp[ia];
        ev0b = hv[ib] && !hp[ib];
        ev1b = hv[ib] && hp[ib];
        if (ev0a) erd0_a = hd[ia];
        if (ev1a) erd1_a = hd[ia];
        if (ev0b) erd0_b = hd[ib];
        if (ev1b) erd1_b = hd[ib];

        chk("a_p0_gnt", 32'(gnt0_a), 32'(g0));
        chk("a_p1_gnt", 32'(gnt1_a), 32'(g1));
        chk("a_stall", 32'(stall_a), 32'(r0 && !g0));
        chk("a_lsu_addr", addr_a, ea);
        chk("a_lsu_wdata", wdata_a, ed);
        chk("a_lsu_bmask", 32'(bmask_a), 32'(em));
        chk("a_lsu_wren", 32'(wren_a), 32'(ew));
        chk("a_p0_rvalid", 32'(rv0_a), 32'(ev0a));
        chk("a_p1_rvalid", 32'(rv1_a), 32'(ev1a));
        chk("a_p0_rdata", rd0_a, erd0_a);
        chk("a_p1_rdata", rd1_a, erd1_a);
        chk("b_p0_gnt", 32'(gnt0_b), 32'(g0));
        chk("b_p1_gnt", 32'(gnt1_b), 32'(g1));
        chk("b_stall", 32'(stall_b), 32'(r0 && !g0));
        chk("b_lsu_addr", addr_b, ea);
        chk("b_lsu_wdata", wdata_b, ed);
        chk("b_lsu_bmask", 32'(bmask_b), 32'(em));
        chk("b_lsu_wren", 32'(wren_b), 32'(ew));
        chk("b_p0_rvalid", 32'(rv0_b), 32'(ev0b));
        chk("b_p1_rvalid", 32'(rv1_b), 32'(ev1b));
        chk("b_p0_rdata", rd0_b, erd0_b);
        chk("b_p1_rdata", rd1_b, erd1_b);
`ifdef LSU_ARB_PERF_EN
        chk("a_perf_conflict", conf_a, 32'(m_conf));
        chk("a_perf_forced", 32'(forc_a), 32'(m_forc));
        chk("b_perf_conflict", conf_b, 32'(m_conf));
        chk("b_perf_forced", 32'(forc_b), 32'(m_forc));
        if (r0 && r1) m_conf++;
        if (g1 && r0 && !hold) m_forc++;
`endif
        // Record this cycle's grant for the response scoreboard and LSU model
        hv[ic]   = (g0 || g1) && !ew;
        hp[ic]   = g1;
        hd[ic]   = rmem(ea);
        ha_a[ic] = addr_a;
        ha_b[ic] = addr_b;
        // Wait counter and lock bookkeeping
        if (g1 || !r1 || brk) m_wait = 0;
        else if (m_wait < SMAX) m_wait++;
        if (hold) begin
            m_run++;
        end else if (g1 && l1) begin
            m_lock = 1;
            m_run  = 1;
        end else begin
            m_lock = 0;
            m_run  = 0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_p0_gnt"}, 32'(gnt0_a | gnt0_b), 32'h0);
        chk({tag, "_p1_gnt"}, 32'(gnt1_a | gnt1_b), 32'h0);
        chk({tag, "_rvalid"}, 32'(rv0_a | rv1_a | rv0_b | rv1_b), 32'h0);
        chk({tag, "_rdata"}, rd0_a | rd1_a | rd0_b | rd1_b, 32'h0);
        chk({tag, "_lsu_addr"}, addr_a | addr_b, 32'h0);
        chk({tag, "_lsu_wren"}, 32'(wren_a | wren_b), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int i = 0; i < 8; i++) begin
            ha_a[i] = 0;
            ha_b[i] = 0;
            hd[i]   = 0;
            hp[i]   = 0;
        end
        // Reset state, with a request pending to show no grant is issued
        @(posedge clk);
        @(negedge clk);
        p0_req = 1; p1_req = 1;
        #1;
        chk_reset_outputs("rst0");
        p0_req = 0; p1_req = 0;
        @(negedge clk);
        rst = 0;

        // Lone CPU read of 0x10
        step(1, 0, 32'h0000_0010, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Both requesting every cycle: starvation bound
        for (int i = 0; i < 12; i++)
            step(1, 0, 32'h100 + 32'(i), 0, 4'h3, 1, 0, 32'h8000 + 32'(i), 0, 4'hC, 0);
        idle(2);

        // Port-1 locked write burst against a busy CPU
        for (int i = 0; i < 40; i++)
            step(1, 0, 32'h200 + 32'(i), 0, 4'h1, 1, 1, 32'h9000 + 32'(i), 32'hD000_0000 + 32'(i), 4'hF, 1);
        idle(2);

        // Interleaved reads P0, P1, P0
        step(1, 0, 32'h0000_0400, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h0000_0404, 0, 4'hF, 0);
        step(1, 0, 32'h0000_0408, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        idle(5);

        // Randomized traffic
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom),
                 $urandom_range(0, 3) != 0);
        idle(5);

        // Asynchronous reset with two reads in flight
        step(1, 0, 32'h0000_0500, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 32'h0000_0504, 0, 4'hF, 0);
        @(negedge clk);
        p0_req = 1; p1_req = 1; p0_wren = 0; p1_wren = 0;
        #1 rst = 1;
        #1;
        chk_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        @(negedge clk);
        p0_req = 0; p1_req = 0; p1_lock = 0;
        rst = 0;
        model_reset();
        idle(6);

        // Short run after reset so counters restart from zero
        for (int i = 0; i < 10; i++)
            step(1, 0, 32'h600 + 32'(i), 0, 4'hF, 1, 0, 32'h700 + 32'(i), 0, 4'hF, 0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
